fp32_to_int32_seq: RTL and testbench

//  Multi-cycle converter from IEEE-754 single precision (FP32) to signed 32-bit integer.

---
 rtl/fp32_to_int32_seq.sv | 197 +++++++++++++++++++
 tb/tb_fp32_to_int32_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int32_seq.sv
// FP32 -> signed int32 converter, truncating toward zero with saturation.
// The operand is classified on accept. Special values finish in one cycle.
// Normal values walk the significand through a barrel of SHIFT_STEP bits
// per cycle, then an optional two's-complement negate, then a held result.
module fp32_to_int32_seq #(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_ovf,
    output logic        out_inv,
    output logic        out_inx
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_SHIFT  = 2'd1;
    localparam logic [1:0]  S_NEGATE = 2'd2;
    localparam logic [1:0]  S_DONE   = 2'd3;

    localparam logic [4:0]  STEP    = 5'(SHIFT_STEP);
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;

    // Biased exponent landmarks: 127 -> e=0, 150 -> e=23 (no shift), 158 -> e=31.
    localparam logic [7:0]  EXP_ONE   = 8'd127;
    localparam logic [7:0]  EXP_UNITY = 8'd150;
    localparam logic [7:0]  EXP_E31   = 8'd158;
    localparam logic [7:0]  EXP_MAX   = 8'd255;

    // Control and datapath state
    logic [1:0]  r_state;
    logic        r_sign;
    logic [31:0] r_sig;
    logic [4:0]  r_rem;
    logic        r_dir_left;
    logic        r_sticky;
    logic [31:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_ovf;
    logic        r_out_inv;
    logic        r_out_inx;

    // Operand fields
    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_mant;
    logic        w_mant_nz;
    logic [31:0] w_sat;
    logic        w_accept;

    // Classification results
    logic        w_special;
    logic [31:0] w_sp_data;
    logic        w_sp_ovf;
    logic        w_sp_inv;
    logic        w_sp_inx;
    logic        w_left;
    logic [4:0]  w_rem;

    // Shift step results
    logic [4:0]  w_k;
    logic [31:0] w_mask;
    logic [31:0] w_sig_next;
    logic        w_lost;
    logic [4:0]  w_rem_next;

    assign w_sign    = in_data[31];
    assign w_exp     = in_data[30:23];
    assign w_mant    = in_data[22:0];
    assign w_mant_nz = |w_mant;
    assign w_sat     = w_sign ? INT_MIN : INT_MAX;

    // Ready is withheld during reset so nothing is captured on the reset edge.
    assign in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_ovf   = r_out_ovf;
    assign out_inv   = r_out_inv;
    assign out_inx   = r_out_inx;

    // Classify the incoming operand: special results or shift direction/amount
    always_comb begin
        w_special = 1'b1;
        w_sp_data = 32'd0;
        w_sp_ovf  = 1'b0;
        w_sp_inv  = 1'b0;
        w_sp_inx  = 1'b0;
        w_left    = 1'b0;
        w_rem     = 5'd0;
        if (w_exp == EXP_MAX) begin
            if (w_mant_nz) begin
                w_sp_data = INT_MIN;
                w_sp_inv  = 1'b1;
            end else begin
                w_sp_data = w_sat;
                w_sp_ovf  = 1'b1;
            end
        end else if (w_exp > EXP_E31) begin
            w_sp_data = w_sat;
            w_sp_ovf  = 1'b1;
        end else if (w_exp == EXP_E31) begin
            // Only -2^31 itself is representable with e==31.
            if (w_sign && !w_mant_nz) begin
                w_sp_data = INT_MIN;
            end else begin
                w_sp_data = w_sat;
                w_sp_ovf  = 1'b1;
            end
        end else if (w_exp < EXP_ONE) begin
            // |x| < 1: result is zero; only exact zeros are exact.
            w_sp_data = 32'd0;
            w_sp_inx  = (w_exp != 8'd0) || w_mant_nz;
        end else begin
            w_special = 1'b0;
            w_left    = (w_exp >= EXP_UNITY);
            w_rem     = w_left ? 5'(w_exp - EXP_UNITY) : 5'(EXP_UNITY - w_exp);
        end
    end

    // One shift step: move by min(SHIFT_STEP, rem), collecting lost bits on right shifts
    always_comb begin
        w_k        = (r_rem < STEP) ? r_rem : STEP;
        w_mask     = (32'd1 << w_k) - 32'd1;
        w_sig_next = r_dir_left ? (r_sig << w_k) : (r_sig >> w_k);
        w_lost     = !r_dir_left && (|(r_sig & w_mask));
        w_rem_next = r_rem - w_k;
    end

    // Sequencer: accept, shift, negate, then hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_data  <= 32'd0;
            r_out_valid <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_inv   <= 1'b0;
            r_out_inx   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign     <= w_sign;
                        r_sig      <= {8'd0, 1'b1, w_mant};
                        r_sticky   <= 1'b0;
                        r_dir_left <= w_left;
                        r_rem      <= w_rem;
                        // Flags restart on every accept; normal path has all-zero sp flags.
                        r_out_ovf  <= w_sp_ovf;
                        r_out_inv  <= w_sp_inv;
                        r_out_inx  <= w_sp_inx;
                        if (w_special) begin
                            r_out_data  <= w_sp_data;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_rem == 5'd0) begin
                            r_state <= S_NEGATE;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_sig    <= w_sig_next;
                    r_rem    <= w_rem_next;
                    r_sticky <= r_sticky | w_lost;
                    if (w_rem_next == 5'd0) begin
                        r_state <= S_NEGATE;
                    end
                end
                S_NEGATE: begin
                    r_out_data  <= r_sign ? (32'd0 - r_sig) : r_sig;
                    r_out_inx   <= r_sticky;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Bench for fp32_to_int32_seq: two instances (SHIFT_STEP 1 and 8) driven
// one at a time, checked against an arithmetic reference model.
module tb_fp32_to_int32_seq;

    logic        clk;
    logic        rst;
    logic [31:0] d_in  [2];
    logic        v_in  [2];
    logic        rdy_in[2];
    logic [31:0] d_out [2];
    logic        v_out [2];
    logic        ordy  [2];
    logic        ovf   [2];
    logic        inv   [2];
    logic        inx   [2];

    int tests = 0;
    int fails = 0;

    fp32_to_int32_seq #(.SHIFT_STEP(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_data(d_in[0]), .in_valid(v_in[0]), .in_ready(rdy_in[0]),
        .out_data(d_out[0]), .out_valid(v_out[0]), .out_ready(ordy[0]),
        .out_ovf(ovf[0]), .out_inv(inv[0]), .out_inx(inx[0])
    );

    fp32_to_int32_seq #(.SHIFT_STEP(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_data(d_in[1]), .in_valid(v_in[1]), .in_ready(rdy_in[1]),
        .out_data(d_out[1]), .out_valid(v_out[1]), .out_ready(ordy[1]),
        .out_ovf(ovf[1]), .out_inv(inv[1]), .out_inx(inx[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact value of the float, truncated, range-checked against int32.
    task automatic ref_model(input logic [31:0] w, input int step,
                             output logic [31:0] od, output logic o, output logic i,
                             output logic x, output int lat);
        int     ex;
        int     sh;
        int     rem;
        logic   s;
        longint mant;
        longint mag;
        longint val;
        longint p;
        s    = w[31];
        ex   = int'(w[30:23]);
        mant = longint'(w[22:0]);
        od = 32'd0; o = 1'b0; i = 1'b0; x = 1'b0; lat = 1;
        if (ex == 255) begin
            if (mant != 0) begin od = 32'h8000_0000; i = 1'b1; end
            else begin od = s ? 32'h8000_0000 : 32'h7FFF_FFFF; o = 1'b1; end
        end else if (ex > 158) begin
            od = s ? 32'h8000_0000 : 32'h7FFF_FFFF; o = 1'b1;
        end else if (ex < 127) begin
            od = 32'd0; x = (w[30:0] != 31'd0);
        end else begin
            mag = 64'd8388608 + mant;
            sh  = ex - 150;
            if (sh >= 0) begin
                mag = mag << sh;
            end else begin
                p   = 64'd1 << (-sh);
                x   = (mag % p) != 0;
                mag = mag / p;
            end
            val = s ? -mag : mag;
            if (val > 64'sd2147483647 || val < -64'sd2147483648) begin
                od = s ? 32'h8000_0000 : 32'h7FFF_FFFF; o = 1'b1; x = 1'b0;
            end else begin
                od = val[31:0];
            end
            rem = (sh < 0) ? -sh : sh;
            lat = (ex == 158) ? 1 : (rem + step - 1) / step + 2;
        end
    endtask

    // Present one operand, then count cycles until out_valid (bounded).
    task automatic do_conv(input int sel, input logic [31:0] w, output logic [31:0] od,
                           output logic o, output logic i, output logic x, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rdy_in[sel] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("ready_wait d%0d", sel), {31'd0, rdy_in[sel]}, 32'd1);
        d_in[sel] = w;
        v_in[sel] = 1'b1;
        @(posedge clk);
        #1 v_in[sel] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!v_out[sel] && lat < 100);
        chk($sformatf("valid_seen d%0d %h", sel, w), {31'd0, v_out[sel]}, 32'd1);
        od = d_out[sel]; o = ovf[sel]; i = inv[sel]; x = inx[sel];
    endtask

    task automatic run_one(input int sel, input logic [31:0] w);
        logic [31:0] od, ed;
        logic        o, i, x, eo, ei, ex;
        int          lat, elat;
        ref_model(w, (sel == 0) ? 1 : 8, ed, eo, ei, ex, elat);
        do_conv(sel, w, od, o, i, x, lat);
        chk($sformatf("data d%0d %h", sel, w), od, ed);
        chk($sformatf("ovf d%0d %h", sel, w), {31'd0, o}, {31'd0, eo});
        chk($sformatf("inv d%0d %h", sel, w), {31'd0, i}, {31'd0, ei});
        chk($sformatf("inx d%0d %h", sel, w), {31'd0, x}, {31'd0, ex});
        chk($sformatf("latency d%0d %h", sel, w), 32'(lat), 32'(elat));
    endtask

    logic [31:0] directed [9] = '{32'h411C0000, 32'h3F100000, 32'h80000000, 32'hC0000000,
                                  32'h4B000001, 32'h4F000000, 32'hCF000000, 32'h7F800000,
                                  32'h7FC00000};

    initial begin
        logic [31:0] od, w;
        logic        o, i, x;
        int          lat, r;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            d_in[k] = 32'd0; v_in[k] = 1'b0; ordy[k] = 1'b1;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst in_ready d%0d", k), {31'd0, rdy_in[k]}, 32'd0);
            chk($sformatf("rst out_valid d%0d", k), {31'd0, v_out[k]}, 32'd0);
            chk($sformatf("rst out_data d%0d", k), d_out[k], 32'd0);
            chk($sformatf("rst flags d%0d", k), {29'd0, ovf[k], inv[k], inx[k]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("post-rst in_ready d%0d", k), {31'd0, rdy_in[k]}, 32'd1);

        // Directed operands on both step sizes
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < 9; n++)
                run_one(k, directed[n]);

        // 9.75 with explicit constants: step 1 latency 22, step 8 latency 5
        do_conv(0, 32'h411C0000, od, o, i, x, lat);
        chk("9.75 s1 data", od, 32'd9);
        chk("9.75 s1 inx", {31'd0, x}, 32'd1);
        chk("9.75 s1 lat", 32'(lat), 32'd22);
        do_conv(1, 32'h411C0000, od, o, i, x, lat);
        chk("9.75 s8 data", od, 32'd9);
        chk("9.75 s8 lat", 32'(lat), 32'd5);

        // Back-pressure: hold out_ready low for 10 cycles in DONE
        ordy[0] = 1'b0;
        do_conv(0, 32'hC0000000, od, o, i, x, lat);
        chk("stall first data", od, 32'hFFFF_FFFE);
        d_in[0] = 32'h40400000;
        v_in[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall out_valid", {31'd0, v_out[0]}, 32'd1);
            chk("stall out_data", d_out[0], 32'hFFFF_FFFE);
            chk("stall in_ready", {31'd0, rdy_in[0]}, 32'd0);
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("idle in_ready", {31'd0, rdy_in[0]}, 32'd1);
        chk("idle out_valid", {31'd0, v_out[0]}, 32'd0);
        @(posedge clk);
        #1 v_in[0] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("busy in_ready", {31'd0, rdy_in[0]}, 32'd0);
        end while (!v_out[0] && lat < 100);
        chk("held 3.0 data", d_out[0], 32'd3);
        chk("held 3.0 flags", {29'd0, ovf[0], inv[0], inx[0]}, 32'd0);
        chk("held 3.0 lat", 32'(lat), 32'd24);

        // Reset in the middle of SHIFT
        @(negedge clk);
        d_in[0] = 32'h411C0000;
        v_in[0] = 1'b1;
        @(posedge clk);
        #1 v_in[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort in_ready in rst", {31'd0, rdy_in[0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort out_valid", {31'd0, v_out[0]}, 32'd0);
        chk("abort out_data", d_out[0], 32'd0);
        chk("abort in_ready", {31'd0, rdy_in[0]}, 32'd1);
        run_one(0, 32'h40400000);

        // Randomised operands, exponent biased toward the interesting range
        for (int n = 0; n < 60; n++) begin
            w = $urandom;
            r = $urandom_range(0, 9);
            if (r < 7)       w[30:23] = 8'($urandom_range(120, 162));
            else if (r == 7) w[30:23] = 8'd255;
            else if (r == 8) w[30:23] = 8'd0;
            if ($urandom_range(0, 7) == 0) w[22:0] = 23'd0;
            run_one(n % 2, w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
